syscall_sequencer: RTL and testbench

//  Sequences SYSCALL services for the single-cycle/pipelined MIPS core. Sits between decode/regfile and the display path.

---
 rtl/syscall_pkg.sv | 14 +
 rtl/syscall_fifo.sv | 53 +++++
 rtl/syscall_sequencer.sv | 124 ++++++++++++
 tb/tb_syscall_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared constants and FSM encoding for the SYSCALL sequencer.
package syscall_pkg;

  localparam logic [31:0] SYS_HALT  = 32'd10;
  localparam logic [31:0] SYS_SLEEP = 32'd32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSleep = 2'd1,
    StDrain = 2'd2,
    StHalt  = 2'd3
  } state_e;

endpackage

// File: rtl/syscall_fifo.sv
// Print FIFO: power-of-two depth, pointers carry an extra wrap bit for full/empty.
module syscall_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              single,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [AW:0]       wr_q, rd_q;
  logic [AW:0]       occupancy;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              push_en, pop_en;

  assign occupancy = wr_q - rd_q;
  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign single    = (occupancy == {{AW{1'b0}}, 1'b1});
  assign head      = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_en) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop_en) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/syscall_sequencer.sv
// SYSCALL service sequencer: print/sleep/halt with stall and PC enable control.
// Optional serviced-syscall counter enabled by macro SYSCALL_COUNT_EN.
module syscall_sequencer
  import syscall_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SLEEP_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              syscall,
  input  logic [31:0]       regSValue,
  input  logic [DATA_W-1:0] regTValue,
  output logic              stall,
  output logic              enable,
  output logic              halted,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] last_value,
  output logic [31:0]       syscall_count
);

  state_e               state_q, state_d;
  logic [SLEEP_W-1:0]   sleep_q, sleep_d;
  logic [DATA_W-1:0]    last_value_q;
  logic                 is_halt, is_sleep, is_print;
  logic                 accept, pop, push;
  logic                 fifo_full, fifo_empty, fifo_single;
  logic [SLEEP_W-1:0]   sleep_arg;

  assign is_halt   = (regSValue == SYS_HALT);
  assign is_sleep  = (regSValue == SYS_SLEEP);
  assign is_print  = !is_halt && !is_sleep;
  assign sleep_arg = regTValue[SLEEP_W-1:0];

  assign accept    = syscall && (state_q == StIdle) && !(is_print && fifo_full);
  assign push      = accept && is_print;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // A syscall presented while halted is dropped rather than stalled.
  assign stall  = (syscall && !accept && (state_q != StHalt)) ||
                  (state_q == StSleep) || (state_q == StDrain);
  assign halted = (state_q == StHalt);
  assign enable = !halted;
  assign last_value = last_value_q;

  syscall_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (regTValue),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .single    (fifo_single),
    .head      (out_data)
  );

  always_comb begin
    state_d = state_q;
    sleep_d = sleep_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_sleep && (sleep_arg != '0)) begin
          sleep_d = sleep_arg;
          state_d = StSleep;
        end else if (accept && is_halt) begin
          state_d = fifo_empty ? StHalt : StDrain;
        end
      end
      StSleep: begin
        if (sleep_q == SLEEP_W'(1)) begin
          state_d = StIdle;
        end
        sleep_d = sleep_q - 1'b1;
      end
      StDrain: begin
        // No pushes happen here, so the last pop is a pop with one entry left.
        if (fifo_empty || (pop && fifo_single)) begin
          state_d = StHalt;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      sleep_q      <= '0;
      last_value_q <= '0;
    end else begin
      state_q <= state_d;
      sleep_q <= sleep_d;
      if (pop) begin
        last_value_q <= out_data;
      end
    end
  end

`ifdef SYSCALL_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign syscall_count = count_q;
`else
  assign syscall_count = 32'h0;
`endif

endmodule

// File: tb/tb_syscall_sequencer.sv
// Directed, table-driven bench for syscall_sequencer plus hand-written reset/counter sequences.
module tb_syscall_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        syscall;
  logic [31:0] regSValue, regTValue;
  logic        stall, enable, halted, out_valid, out_ready;
  logic [31:0] out_data, last_value, syscall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          sc;
    logic [31:0] v0;
    logic [31:0] a0;
    bit          rdy;
    bit          st;
    bit          ov;
    logic [31:0] od;
    logic [31:0] lv;
    bit          hl;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  syscall_sequencer #(
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .SLEEP_W    (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .syscall       (syscall),
    .regSValue     (regSValue),
    .regTValue     (regTValue),
    .stall         (stall),
    .enable        (enable),
    .halted        (halted),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .last_value    (last_value),
    .syscall_count (syscall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit sc, input logic [31:0] v0, input logic [31:0] a0, input bit rdy,
                     input bit st, input bit ov, input logic [31:0] od, input logic [31:0] lv,
                     input bit hl);
    vec_t v;
    v.sc = sc; v.v0 = v0; v.a0 = a0; v.rdy = rdy;
    v.st = st; v.ov = ov; v.od = od; v.lv = lv; v.hl = hl;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit sc, input logic [31:0] v0, input logic [31:0] a0, input bit rdy);
    syscall = sc; regSValue = v0; regTValue = a0; out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  logic [31:0] exp_cnt;

  initial begin
    // Print 0x1234 with ready high
    add(1, 1, 32'h1234, 1,  0, 0, 0,         0,         0);
    add(0, 0, 0,        1,  0, 1, 32'h1234,  0,         0);
    add(0, 0, 0,        1,  0, 0, 0,         32'h1234,  0);
    // Five back-to-back prints with ready low; fifth waits for space
    add(1, 1, 1, 0,  0, 0, 0, 32'h1234, 0);
    add(1, 1, 2, 0,  0, 1, 1, 32'h1234, 0);
    add(1, 1, 3, 0,  0, 1, 1, 32'h1234, 0);
    add(1, 1, 4, 0,  0, 1, 1, 32'h1234, 0);
    add(1, 1, 5, 0,  1, 1, 1, 32'h1234, 0);
    add(1, 1, 5, 1,  1, 1, 1, 32'h1234, 0);
    add(1, 1, 5, 0,  0, 1, 2, 1,        0);
    add(0, 0, 0, 1,  0, 1, 2, 1,        0);
    add(0, 0, 0, 1,  0, 1, 3, 2,        0);
    add(0, 0, 0, 1,  0, 1, 4, 3,        0);
    add(0, 0, 0, 1,  0, 1, 5, 4,        0);
    add(0, 0, 0, 1,  0, 0, 0, 5,        0);
    // Sleep 3: stall for exactly three cycles after accept
    add(1, 32, 3, 0,  0, 0, 0, 5, 0);
    add(0, 0,  0, 0,  1, 0, 0, 5, 0);
    add(0, 0,  0, 0,  1, 0, 0, 5, 0);
    add(0, 0,  0, 0,  1, 0, 0, 5, 0);
    add(0, 0,  0, 0,  0, 0, 0, 5, 0);
    // Sleep 0: no stall
    add(1, 32, 0, 0,  0, 0, 0, 5, 0);
    add(0, 0,  0, 0,  0, 0, 0, 5, 0);
    // Sleep 1 with a print held behind it
    add(1, 32, 1,     0,  0, 0, 0,     5, 0);
    add(1, 1,  32'h77, 0, 1, 0, 0,     5, 0);
    add(1, 1,  32'h77, 0, 0, 0, 0,     5, 0);
    add(0, 0,  0,     0,  0, 1, 32'h77, 5, 0);
    // Second entry, then halt with two queued: DRAIN two cycles, then HALT
    add(1, 1,  32'h88, 0, 0, 1, 32'h77, 5,     0);
    add(1, 10, 0,      0, 0, 1, 32'h77, 5,     0);
    add(0, 0,  0,      1, 1, 1, 32'h77, 5,     0);
    add(0, 0,  0,      1, 1, 1, 32'h88, 32'h77, 0);
    add(1, 1,  32'h99, 1, 0, 0, 0,      32'h88, 1);
    add(1, 1,  32'h99, 1, 0, 0, 0,      32'h88, 1);
    add(0, 0,  0,      1, 0, 0, 0,      32'h88, 1);

    do_reset();
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_enable", {31'd0, enable}, 32'd1);
    check("reset_count", syscall_count, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sc, vecs[i].v0, vecs[i].a0, vecs[i].rdy);
      @(negedge clock);
      check($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].st});
      check($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
      if (vecs[i].ov) check($sformatf("v%0d_data", i), out_data, vecs[i].od);
      check($sformatf("v%0d_last", i), last_value, vecs[i].lv);
      check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].hl});
      check($sformatf("v%0d_enable", i), {31'd0, enable}, {31'd0, !vecs[i].hl});
      step();
    end
`ifdef SYSCALL_COUNT_EN
    exp_cnt = 32'd12;
`else
    exp_cnt = 32'd0;
`endif
    check("trace_count", syscall_count, exp_cnt);

    // Three prints and a sleep, then reset mid-SLEEP with a concurrent pop request
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'd1, 32'(i), 1'b0);
      step();
    end
    drive(1'b1, 32'd32, 32'd5, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    step();
    @(negedge clock);
    check("sleep_stall", {31'd0, stall}, 32'd1);
    check("sleep_valid", {31'd0, out_valid}, 32'd1);
    check("sleep_head", out_data, 32'd1);
`ifdef SYSCALL_COUNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    check("count_4", syscall_count, exp_cnt);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_last", last_value, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_count", syscall_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
